// File: rtl/mem_access_ctrl_if.sv
// Memory-stage request/response bundle and data-bus handshake signals for mem_access_ctrl.
// The slave view belongs to the controller; the master view belongs to the pipeline/bus side.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_msize;
    logic              req_unsigned;
    logic [63:0]       req_wdata;
    logic              flush;
    logic              stall;
    logic              done;
    logic [63:0]       rdata;
    logic              misalign;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [1:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [63:0]       dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [63:0]       dresp_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_msize, req_unsigned, req_wdata, flush,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        output stall, done, rdata, misalign,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_msize, req_unsigned, req_wdata, flush,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        input  stall, done, rdata, misalign,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: builds a data-bus request from a load/store, runs the
// addr_ok/data_ok handshake, stalls the pipeline and returns the extended load result.
module mem_access_ctrl #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  mif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              write_q;
    logic [7:0]        strobe_q;
    logic [63:0]       wdata_q;
    logic              valid_q;
    logic              done_q;
    logic              misalign_q;
    logic [63:0]       rdata_q;

    logic              misaligned_c;
    logic [7:0]        strobe_c;
    logic [63:0]       lane_data_c;
    logic [63:0]       shifted_c;
    logic [63:0]       load_c;
    logic              stall_c;

    always_comb begin
        misaligned_c = 1'b0;
        strobe_c     = 8'hFF;
        case (mif.req_msize)
            2'd0: strobe_c = 8'h01 << mif.req_addr[2:0];
            2'd1: begin
                misaligned_c = mif.req_addr[0];
                strobe_c     = 8'h03 << {mif.req_addr[2:1], 1'b0};
            end
            2'd2: begin
                misaligned_c = |mif.req_addr[1:0];
                strobe_c     = 8'h0F << {mif.req_addr[2], 2'b00};
            end
            default: begin
                misaligned_c = |mif.req_addr[2:0];
                strobe_c     = 8'hFF;
            end
        endcase
        lane_data_c = mif.req_wdata << {mif.req_addr[2:0], 3'b000};
    end

    // Extraction uses the latched request, so it is valid whenever data_ok arrives.
    always_comb begin
        shifted_c = mif.dresp_data >> {addr_q[2:0], 3'b000};
        load_c    = shifted_c;
        case (size_q)
            2'd0: load_c = unsigned_q ? {56'd0, shifted_c[7:0]}
                                      : {{56{shifted_c[7]}}, shifted_c[7:0]};
            2'd1: load_c = unsigned_q ? {48'd0, shifted_c[15:0]}
                                      : {{48{shifted_c[15]}}, shifted_c[15:0]};
            2'd2: load_c = unsigned_q ? {32'd0, shifted_c[31:0]}
                                      : {{32{shifted_c[31]}}, shifted_c[31:0]};
            default: load_c = shifted_c;
        endcase
        if (write_q) begin
            load_c = '0;
        end
    end

    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:      stall_c = mif.req_valid & ~mif.flush;
            REQ, WAIT: stall_c = ~mif.flush;
            default:   stall_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            strobe_q   <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mif.req_valid && !mif.flush) begin
                        if (misaligned_c) begin
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            rdata_q    <= '0;
                            state      <= DONE;
                        end else begin
                            addr_q     <= mif.req_addr;
                            size_q     <= mif.req_msize;
                            unsigned_q <= mif.req_unsigned;
                            write_q    <= mif.req_write;
                            strobe_q   <= mif.req_write ? strobe_c : 8'h00;
                            wdata_q    <= lane_data_c;
                            valid_q    <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mif.flush) begin
                        // An accepted-but-incomplete request still owes a data_ok: drain it.
                        valid_q <= 1'b0;
                        state   <= (mif.dresp_addr_ok && !mif.dresp_data_ok) ? DRAIN : IDLE;
                    end else if (mif.dresp_addr_ok) begin
                        valid_q <= 1'b0;
                        if (mif.dresp_data_ok) begin
                            rdata_q <= load_c;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mif.dresp_data_ok) begin
                        if (mif.flush) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= load_c;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end else if (mif.flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mif.dresp_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mif.stall       = stall_c;
    assign mif.done        = done_q;
    assign mif.misalign    = misalign_q;
    assign mif.rdata       = rdata_q;
    assign mif.dreq_valid  = valid_q;
    assign mif.dreq_addr   = addr_q;
    assign mif.dreq_size   = size_q;
    assign mif.dreq_strobe = strobe_q;
    assign mif.dreq_data   = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer between the pipeline's memory stage and the data bus.
- Accepts one load/store per operation and builds the bus request: address, size, byte strobe and lane-shifted write data.
- Runs the addr_ok/data_ok handshake and stalls the pipeline until the access completes.
- Returns the load result right-aligned and sign/zero-extended, flags misaligned accesses, and drains any in-flight bus transaction on flush.

Parameters:
- ADDR_W, 64, address width (data path fixed at 64 bits / 8 byte lanes)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  memory stage holds a load/store
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_msize  in  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- req_unsigned  in  1  zero-extend load result
- req_wdata  in  64  store data, right-aligned
- flush  in  1  pipeline squash of the current operation
- stall  out  1  hold memory stage and all earlier stages
- done  out  1  one-cycle completion pulse
- rdata  out  64  extended load result; valid while done = 1
- misalign  out  1  qualifies done: access was misaligned, no bus traffic issued
- dreq_valid  out  1  bus request valid
- dreq_addr  out  ADDR_W  bus address (latched req_addr)
- dreq_size  out  2  latched msize
- dreq_strobe  out  8  byte-lane write enables; 0 for loads
- dreq_data  out  64  store data placed on its byte lanes
- dresp_addr_ok  in  1  bus accepted the request
- dresp_data_ok  in  1  bus completed the access
- dresp_data  in  64  raw 64-bit bus read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset (asynchronous, any state): IDLE. dreq_valid = 0, done = 0, misalign = 0, rdata = 0, all latched request fields = 0. stall is combinational and equals req_valid & ~flush while in IDLE.
- IDLE, aligned request (req_valid & ~flush): latch addr, msize, unsigned, write and wdata; go to REQ. stall = 1.
- IDLE, misaligned request: go to DONE with misalign = 1. No bus request is issued. stall = 1 in that cycle.
  - Misaligned means: 2B with addr[0] ≠ 0; 4B with addr[1:0] ≠ 0; 8B with addr[2:0] ≠ 0.
- REQ: dreq_valid = 1 and the dreq_* fields hold stable until addr_ok.
  - addr_ok & data_ok in the same cycle: capture data, go to DONE.
  - addr_ok alone: go to WAIT.
  - flush before addr_ok: go to IDLE. dreq_valid drops the next cycle.
- WAIT: dreq_valid = 0. On data_ok, capture data and go to DONE. flush in WAIT goes to DRAIN.
- DRAIN: stall = 0; no new request is accepted. On data_ok, discard the data and go to IDLE. done is not pulsed.
- DONE (exactly 1 cycle): done = 1, stall = 0, rdata and misalign valid; go to IDLE.
  - The pipeline advances this cycle, so a new op is seen in IDLE on the next cycle.
  - Minimum latency with both oks arriving together: req_valid at T, bus request at T+1, done at T+2.
- Strobe generation:
  - 1B: 1 << addr[2:0]
  - 2B: 8'h03 << (2·addr[2:1])
  - 4B: 8'h0F << (4·addr[2])
  - 8B: 8'hFF
- Store data: dreq_data = req_wdata << (8·addr[2:0]).
- Load extraction, registered into rdata at capture:
  - Shift dresp_data right by 8·addr[2:0].
  - Keep 8, 16 or 32 bits for 1B, 2B or 4B; bit 8·size−1 is the sign unless unsigned. 8B passes through unchanged.
  - For stores, rdata = 0.
- Simultaneous flush & data_ok in WAIT: discard the data, go to IDLE (no DRAIN). done stays 0.
- stall is never asserted in DONE or DRAIN.
- Back-to-back operations are separated by the DONE cycle.

Test Plan:
- Load 1B signed, addr 0x…03; bus returns 0x0000_0000_8000_0000 with addr_ok & data_ok together → strobe 0, done at T+2, rdata 0xFFFF_FFFF_FFFF_FF80.
- Load 4B unsigned, addr 0x…04; data 0xDEAD_BEEF_0000_0000; addr_ok at T+1, data_ok at T+4 → stall held T..T+4, done at T+5, rdata 0x0000_0000_DEAD_BEEF.
- Store 2B, addr 0x…06, wdata 0x1234 → dreq_strobe 0xC0, dreq_data 0x1234_0000_0000_0000, dreq_valid held three cycles until addr_ok, then done.
- Load 8B at addr 0x…04 → misalign = 1 and done = 1 one cycle after req_valid, dreq_valid never asserted, stall deasserted in DONE.
- Flush while in WAIT, data_ok two cycles later → no done pulse, stall 0 in DRAIN, new req_valid accepted only after return to IDLE.
- reset pulse while in REQ → dreq_valid = 0 immediately (asynchronous), state IDLE, next load completes normally.
